core_boot_ctrl: RTL

- Boot/run controller for the single-cycle RV32I core.
- Holds the core in reset while a program image is streamed into instruction memory over a valid/ready interface. Then releases core reset and gates core execution through a clock-enable.
- Provides run, halt and single-step control for bring-up and for the testbench.
- Sits between the top-level test/loader logic and the core's i_reset and instruction-memory write port.

---
 rtl/core_boot_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/core_boot_ctrl.sv
// Boot/run controller for the RV32I core: streams a program image into
// instruction memory while the core is held in reset, then gates execution.
module core_boot_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int RST_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  input  logic              i_run,
  input  logic              i_halt,
  input  logic              i_step,
  output logic              o_imem_wren,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_core_clk_en,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic [2:0]        o_state,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HALT    = 3'd4,
    S_STEP    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  localparam int              RC_W     = $clog2(RST_CYC + 1);
  localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              clk_en_q, clk_en_d;
  logic              err_q, err_d;
  logic              accept;

  always_comb begin
    state_d   = state_q;
    word_cnt_d = word_cnt_q;
    rst_cnt_d = '0;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    accept    = i_ld_valid & ld_ready_q;

    // Write port lags the accepted beat by one cycle; addr/wdata hold otherwise.
    if (accept) begin
      wren_d     = 1'b1;
      addr_d     = word_cnt_q[ADDR_W-1:0];
      wdata_d    = i_ld_data;
      word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = i_ld_last ? S_RELEASE : S_LOAD;
        end else if (i_run) begin
          state_d = S_RELEASE;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (i_ld_last) begin
            state_d = S_RELEASE;
          end else if (word_cnt_q == LAST_IDX) begin
            state_d = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        if (i_halt) state_d = S_HALT;
      end
      S_HALT: begin
        if (i_run) begin
          state_d = S_RUN;
        end else if (i_step) begin
          state_d = S_STEP;
        end
      end
      S_STEP:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // Outputs are decoded from the next state so they register glitch-free
    // and line up with the state they describe.
    ld_ready_d   = ((state_d == S_IDLE) || (state_d == S_LOAD)) &&
                   (word_cnt_d < DEPTH_C);
    core_reset_d = (state_d == S_RUN) || (state_d == S_HALT) ||
                   (state_d == S_STEP);
    clk_en_d     = (state_d == S_RUN) || (state_d == S_STEP);
    err_d        = err_q | (state_d == S_ERROR);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      ld_ready_q   <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b0;
      clk_en_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      ld_ready_q   <= ld_ready_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      err_q        <= err_d;
    end
  end

  assign o_ld_ready    = ld_ready_q;
  assign o_imem_wren   = wren_q;
  assign o_imem_addr   = addr_q;
  assign o_imem_wdata  = wdata_q;
  assign o_core_reset  = core_reset_q;
  assign o_core_clk_en = clk_en_q;
  assign o_word_cnt    = word_cnt_q;
  assign o_state       = state_q;
  assign o_err         = err_q;

endmodule
